// File: rtl/upsample_stream_if.sv
// Streaming handshake bundle for upsample_stream: input element stream in, upsampled stream out.
// The slave modport is the upsampler's view; the master modport is the producer/consumer side.
interface upsample_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/upsample_stream.sv
// Nearest-neighbour upsampler: each element is repeated SCALE times per row, and each row is
// replayed SCALE-1 more times from a one-row line buffer, with a single registered output stage.
module upsample_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int IN_HEIGHT  = 14,
    parameter int IN_WIDTH   = 14,
    parameter int CHANNELS   = 1,
    parameter int SCALE      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    upsample_stream_if.slave bus
);
    localparam int HX_W  = (SCALE > 1)     ? $clog2(SCALE)     : 1;
    localparam int COL_W = (IN_WIDTH > 1)  ? $clog2(IN_WIDTH)  : 1;
    localparam int ROW_W = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
    localparam int CH_W  = (CHANNELS > 1)  ? $clog2(CHANNELS)  : 1;

    localparam logic [HX_W-1:0]  HX_LAST  = HX_W'(SCALE - 1);
    localparam logic [HX_W-1:0]  VY_LAST  = HX_W'(SCALE - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_HEIGHT - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);

    typedef enum logic {LIVE, REPLAY} state_t;

    state_t           state, state_nx;
    logic [HX_W-1:0]  hx, hx_nx, vy, vy_nx;
    logic [COL_W-1:0] col, col_nx;
    logic [ROW_W-1:0] row, row_nx;
    logic [CH_W-1:0]  ch, ch_nx;

    logic [DATA_WIDTH-1:0] data_p0;
    logic                  vld_p0;
    logic                  last_p0;
    logic [DATA_WIDTH-1:0] line_buf [IN_WIDTH];

    logic slot_free, take, load, elem_last;

    // The counters index the next element to be loaded into the output register,
    // so a new input can be accepted while the previous element is still draining.
    assign slot_free    = !vld_p0 || bus.out_ready;
    assign bus.in_ready = rst_n && (state == LIVE) && (hx == '0) && slot_free;
    assign take         = bus.in_valid && bus.in_ready;
    assign elem_last    = (ch == CH_LAST) && (row == ROW_LAST) && (vy == VY_LAST) &&
                          (col == COL_LAST) && (hx == HX_LAST);

    assign bus.out_valid = vld_p0;
    assign bus.out_data  = data_p0;
    assign bus.out_last  = last_p0;

    always_comb begin
        state_nx = state;
        hx_nx    = hx;
        col_nx   = col;
        vy_nx    = vy;
        row_nx   = row;
        ch_nx    = ch;
        load     = 1'b0;
        if (slot_free) load = (state == REPLAY) || (hx != '0) || take;
        if (load) begin
            if (hx != HX_LAST) begin
                hx_nx = hx + 1'b1;
            end else begin
                hx_nx = '0;
                if (col != COL_LAST) begin
                    col_nx = col + 1'b1;
                end else begin
                    col_nx = '0;
                    if (vy != VY_LAST) begin
                        vy_nx    = vy + 1'b1;
                        state_nx = REPLAY;
                    end else begin
                        vy_nx    = '0;
                        state_nx = LIVE;
                        if (row != ROW_LAST) begin
                            row_nx = row + 1'b1;
                        end else begin
                            row_nx = '0;
                            ch_nx  = (ch == CH_LAST) ? '0 : ch + 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Output stage p0: fresh input, held value for horizontal replicas, or line buffer in REPLAY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= LIVE;
            hx      <= '0;
            col     <= '0;
            vy      <= '0;
            row     <= '0;
            ch      <= '0;
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
            data_p0 <= '0;
        end else begin
            state <= state_nx;
            hx    <= hx_nx;
            col   <= col_nx;
            vy    <= vy_nx;
            row   <= row_nx;
            ch    <= ch_nx;
            if (load) begin
                vld_p0  <= 1'b1;
                last_p0 <= elem_last;
                if (state == REPLAY) data_p0 <= line_buf[col];
                else if (hx == '0)   data_p0 <= bus.in_data;
            end else if (slot_free) begin
                vld_p0  <= 1'b0;
                last_p0 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (take) line_buf[col] <= bus.in_data;
    end
endmodule

// File: tb/tb_upsample_stream.sv
// Bench for upsample_stream: three configurations checked every cycle against a
// frame-indexed reference, plus directed sequences with literal expectations.
module tb_upsample_stream;
    function automatic int cfg_h(int g); case (g) 0: return 2; 1: return 1; default: return 3; endcase endfunction
    function automatic int cfg_w(int g); case (g) 0: return 2; 1: return 3; default: return 3; endcase endfunction
    function automatic int cfg_c(int g); case (g) 0: return 2; default: return 1; endcase endfunction
    function automatic int cfg_s(int g); case (g) 0: return 2; 1: return 2; default: return 1; endcase endfunction

    localparam int LOGN = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    initial forever begin @(posedge clk); cyc++; end

    logic [2:0] rst_n_d, in_valid_d, out_ready_d;
    logic [2:0] in_ready_m, out_valid_m, out_last_m;
    logic [7:0] in_data_d [3];
    logic [7:0] out_data_m [3];

    logic [7:0] log_data [3][LOGN];
    logic       log_last [3][LOGN];
    int         log_cyc  [3][LOGN];
    int         log_n    [3] = '{0, 0, 0};
    int         acc_cyc  [3] = '{0, 0, 0};

    logic [7:0] e31 [16] = '{8'd1, 8'd1, 8'd2, 8'd2, 8'd1, 8'd1, 8'd2, 8'd2,
                             8'd3, 8'd3, 8'd4, 8'd4, 8'd3, 8'd3, 8'd4, 8'd4};
    logic [7:0] e35 [16] = '{8'd9, 8'd9, 8'd8, 8'd8, 8'd9, 8'd9, 8'd8, 8'd8,
                             8'd7, 8'd7, 8'd6, 8'd6, 8'd7, 8'd7, 8'd6, 8'd6};
    logic [7:0] e33 [12] = '{8'd10, 8'd10, 8'd20, 8'd20, 8'd30, 8'd30,
                             8'd10, 8'd10, 8'd20, 8'd20, 8'd30, 8'd30};

    upsample_stream_if #(.DATA_WIDTH(8)) bus0 ();
    upsample_stream_if #(.DATA_WIDTH(8)) bus1 ();
    upsample_stream_if #(.DATA_WIDTH(8)) bus2 ();

    assign bus0.in_valid = in_valid_d[0];
    assign bus0.in_data  = in_data_d[0];
    assign bus0.out_ready = out_ready_d[0];
    assign in_ready_m[0]  = bus0.in_ready;
    assign out_valid_m[0] = bus0.out_valid;
    assign out_last_m[0]  = bus0.out_last;
    assign out_data_m[0]  = bus0.out_data;

    assign bus1.in_valid = in_valid_d[1];
    assign bus1.in_data  = in_data_d[1];
    assign bus1.out_ready = out_ready_d[1];
    assign in_ready_m[1]  = bus1.in_ready;
    assign out_valid_m[1] = bus1.out_valid;
    assign out_last_m[1]  = bus1.out_last;
    assign out_data_m[1]  = bus1.out_data;

    assign bus2.in_valid = in_valid_d[2];
    assign bus2.in_data  = in_data_d[2];
    assign bus2.out_ready = out_ready_d[2];
    assign in_ready_m[2]  = bus2.in_ready;
    assign out_valid_m[2] = bus2.out_valid;
    assign out_last_m[2]  = bus2.out_last;
    assign out_data_m[2]  = bus2.out_data;

    upsample_stream #(.DATA_WIDTH(8), .IN_HEIGHT(2), .IN_WIDTH(2), .CHANNELS(2), .SCALE(2))
        u_dut0 (.clk(clk), .rst_n(rst_n_d[0]), .bus(bus0));
    upsample_stream #(.DATA_WIDTH(8), .IN_HEIGHT(1), .IN_WIDTH(3), .CHANNELS(1), .SCALE(2))
        u_dut1 (.clk(clk), .rst_n(rst_n_d[1]), .bus(bus1));
    upsample_stream #(.DATA_WIDTH(8), .IN_HEIGHT(3), .IN_WIDTH(3), .CHANNELS(1), .SCALE(1))
        u_dut2 (.clk(clk), .rst_n(rst_n_d[2]), .bus(bus2));

    task automatic chk(int g, string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s dut%0d actual=%0d required=%0d", name, g, act, req);
        end
    endtask

    // Reference: output k of a frame is (c, y, x) and must equal input (c, y/S, x/S) of that frame.
    for (genvar g = 0; g < 3; g++) begin : mon
        localparam int H = cfg_h(g);
        localparam int W = cfg_w(g);
        localparam int C = cfg_c(g);
        localparam int S = cfg_s(g);
        localparam int OW  = W * S;
        localparam int OPF = C * H * S * OW;
        localparam int IPF = C * H * W;
        logic [7:0] inq [$];
        int   k = 0;
        bit   stall = 0;
        logic [7:0] prev_d;
        logic prev_l;
        initial forever begin
            @(negedge clk);
            if (!rst_n_d[g]) begin
                chk(g, "rst_out_valid", int'(out_valid_m[g]), 0);
                chk(g, "rst_out_last", int'(out_last_m[g]), 0);
                chk(g, "rst_out_data", int'(out_data_m[g]), 0);
                chk(g, "rst_in_ready", int'(in_ready_m[g]), 0);
                inq.delete();
                k = 0;
                stall = 0;
            end else begin
                int r, f, c, rem, y, x, ii;
                if (stall) begin
                    chk(g, "hold_valid", int'(out_valid_m[g]), 1);
                    chk(g, "hold_data", int'(out_data_m[g]), int'(prev_d));
                    chk(g, "hold_last", int'(out_last_m[g]), int'(prev_l));
                end
                if (out_valid_m[g] && !out_ready_d[g])
                    chk(g, "stall_in_ready", int'(in_ready_m[g]), 0);
                if (in_valid_d[g] && in_ready_m[g]) inq.push_back(in_data_d[g]);
                if (out_valid_m[g] && out_ready_d[g]) begin
                    f   = k / OPF;
                    r   = k % OPF;
                    c   = r / (H * S * OW);
                    rem = r % (H * S * OW);
                    y   = rem / OW;
                    x   = rem % OW;
                    ii  = f * IPF + c * H * W + (y / S) * W + (x / S);
                    if (ii >= inq.size()) begin
                        checks++;
                        failures++;
                        $display("FAIL out_source dut%0d actual=element %0d required=one of first %0d inputs",
                                 g, ii, inq.size());
                    end else begin
                        chk(g, "out_data", int'(out_data_m[g]), int'(inq[ii]));
                    end
                    chk(g, "out_last", int'(out_last_m[g]), (r == OPF - 1) ? 1 : 0);
                    if (log_n[g] < LOGN) begin
                        log_data[g][log_n[g]] = out_data_m[g];
                        log_last[g][log_n[g]] = out_last_m[g];
                        log_cyc[g][log_n[g]]  = cyc;
                    end
                    log_n[g]++;
                    k++;
                end
                stall  = out_valid_m[g] && !out_ready_d[g];
                prev_d = out_data_m[g];
                prev_l = out_last_m[g];
            end
        end
    end

    task automatic send(int i, logic [7:0] d);
        int t;
        bit got;
        t = 0;
        got = 0;
        in_valid_d[i] = 1'b1;
        in_data_d[i]  = d;
        while (!got && t < 200) begin
            @(negedge clk);
            got = in_ready_m[i];
            if (got) acc_cyc[i] = cyc;
            @(posedge clk);
            #1;
            t++;
        end
        in_valid_d[i] = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL send_accept dut%0d actual=not accepted required=accepted within 200 cycles", i);
        end
    endtask

    task automatic wait_n(int i, int target);
        int t;
        t = 0;
        while (log_n[i] < target && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
    endtask

    task automatic rand_run(int i, int n);
        int base, sent, t, s;
        bit done;
        base = log_n[i];
        s = cfg_s(i);
        sent = 0;
        done = 0;
        t = 0;
        fork
            begin
                in_valid_d[i] = 1'b0;
                while (sent < n && t < 4000) begin
                    @(negedge clk);
                    if (in_valid_d[i] && in_ready_m[i]) sent++;
                    @(posedge clk);
                    #1;
                    t++;
                    if (sent < n && $urandom_range(0, 3) != 0) begin
                        in_valid_d[i] = 1'b1;
                        in_data_d[i]  = 8'($urandom);
                    end else begin
                        in_valid_d[i] = 1'b0;
                    end
                end
                in_valid_d[i] = 1'b0;
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready_d[i] = ($urandom_range(0, 2) != 0);
                end
                out_ready_d[i] = 1'b1;
            end
        join
        chk(i, "rand_sent", sent, n);
        wait_n(i, base + n * s * s);
        repeat (4) @(posedge clk);
        #1;
        chk(i, "rand_out_count", log_n[i], base + n * s * s);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int gaps, lasts, base, lowcnt, a0;
        rst_n_d     = 3'b000;
        in_valid_d  = 3'b000;
        out_ready_d = 3'b111;
        for (int j = 0; j < 3; j++) in_data_d[j] = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n_d = 3'b111;
        @(posedge clk);
        #1;

        // 2x2 frames, two channels, two frames back to back
        for (int j = 0; j < 16; j++) send(0, 8'((j < 8) ? j + 1 : j + 3));
        wait_n(0, 64);
        repeat (4) @(posedge clk);
        #1;
        chk(0, "frames_out_count", log_n[0], 64);
        for (int j = 0; j < 16; j++) chk(0, "lit_2x2_seq", int'(log_data[0][j]), int'(e31[j]));
        gaps = 0;
        lasts = 0;
        for (int j = 1; j < 64; j++) if (log_cyc[0][j] != log_cyc[0][0] + j) gaps++;
        for (int j = 0; j < 64; j++) if (log_last[0][j]) lasts++;
        chk(0, "frames_gap_cycles", gaps, 0);
        chk(0, "frames_last_total", lasts, 2);
        chk(0, "last_at_32", int'(log_last[0][31]), 1);
        chk(0, "last_at_64", int'(log_last[0][63]), 1);
        chk(0, "lit_ch1_first", int'(log_data[0][16]), 5);
        chk(0, "lit_frame2_first", int'(log_data[0][32]), 11);
        chk(0, "lit_frame2_last", int'(log_data[0][63]), 18);

        // Back-pressure: out_ready low for 3 cycles while data is pending
        fork
            for (int j = 0; j < 8; j++) send(0, 8'(40 + j));
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready_d[0] = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready_d[0] = 1'b1;
            end
        join
        wait_n(0, 96);
        repeat (4) @(posedge clk);
        #1;
        chk(0, "stall_out_count", log_n[0], 96);

        // Reset after 5 transfers of a partial frame, then a fresh frame
        send(0, 8'd1);
        send(0, 8'd2);
        wait_n(0, 101);
        chk(0, "pre_reset_count", log_n[0], 101);
        rst_n_d[0] = 1'b0;
        #1;
        chk(0, "async_rst_out_valid", int'(out_valid_m[0]), 0);
        chk(0, "async_rst_in_ready", int'(in_ready_m[0]), 0);
        chk(0, "async_rst_out_data", int'(out_data_m[0]), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n_d[0] = 1'b1;
        @(posedge clk);
        #1;
        base = log_n[0];
        for (int j = 0; j < 8; j++) send(0, 8'(9 - j));
        wait_n(0, base + 32);
        for (int j = 0; j < 16; j++) chk(0, "lit_after_reset", int'(log_data[0][base + j]), int'(e35[j]));
        chk(0, "after_reset_last", int'(log_last[0][base + 31]), 1);

        // 1x3 rows: in_valid held high through the replay row must not be consumed.
        // in_ready stays low for the final live replica plus the 6 replay elements.
        send(1, 8'd10);
        send(1, 8'd20);
        send(1, 8'd30);
        in_valid_d[1] = 1'b1;
        in_data_d[1]  = 8'd99;
        lowcnt = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (in_ready_m[1]) break;
            lowcnt++;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        in_valid_d[1] = 1'b0;
        chk(1, "replay_in_ready_low_cycles", lowcnt, 7);
        send(1, 8'd98);
        send(1, 8'd97);
        wait_n(1, 24);
        for (int j = 0; j < 12; j++) chk(1, "lit_1x3_seq", int'(log_data[1][j]), int'(e33[j]));
        chk(1, "lit_1x3_next_frame", int'(log_data[1][12]), 99);
        chk(1, "lit_1x3_last", int'(log_last[1][11]), 1);

        // SCALE=1 pass-through, 3x3
        send(2, 8'd21);
        a0 = acc_cyc[2];
        for (int j = 1; j < 9; j++) send(2, 8'(21 + j));
        wait_n(2, 9);
        chk(2, "pass_latency", log_cyc[2][0], a0 + 1);
        for (int j = 0; j < 9; j++) chk(2, "lit_pass_seq", int'(log_data[2][j]), 21 + j);
        chk(2, "pass_last_9th", int'(log_last[2][8]), 1);
        chk(2, "pass_last_8th", int'(log_last[2][7]), 0);

        // Randomized traffic with random back-pressure on all three configurations
        fork
            rand_run(0, 24);
            rand_run(1, 9);
            rand_run(2, 18);
        join

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
